// File: rtl/uartprobe_uart_pkg.sv
// Shared encodings and constants for the probe UART (8N1, optional even parity).
// Optional feature macro: UARTPROBE_UART_PARITY_EN.
package uartprobe_uart_pkg;

  localparam logic LINE_IDLE = 1'b1;
  localparam int   DATA_BITS = 8;
  localparam int   IDX_W     = 3;

`ifdef UARTPROBE_UART_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/uartprobe_uart_rx.sv
// UART receiver: 2-flop synchroniser, RX FSM, one-byte holding buffer, error pulses.
// Byte valid one cycle after the mid-stop sample; a full buffer without rx_ready drops the new byte (rx_overrun).
module uartprobe_uart_rx
  import uartprobe_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BIT_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 uart_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);

  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] FULL_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_e              state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rxs_q, rxs_d;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   rx_vld_q, rx_vld_d;
  logic [DATA_BITS-1:0]   rx_dat_q, rx_dat_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   byte_done;
`ifdef UARTPROBE_UART_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   par_err_q, par_err_d;
`endif

  always_comb begin
    rx_meta_d   = uart_rx;
    rxs_d       = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q + BIT_CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
`ifdef UARTPROBE_UART_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
`ifdef UARTPROBE_UART_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (rxs_q != LINE_IDLE) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit in so short glitches are ignored.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (rxs_q == LINE_IDLE) ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UARTPROBE_UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UARTPROBE_UART_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_STOP;
          if (rxs_q != even_parity(shift_q)) begin
            par_bad_d = 1'b1;
            par_err_d = 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rxs_q == LINE_IDLE) begin
`ifdef UARTPROBE_UART_PARITY_EN
            byte_done = !par_bad_q;
`else
            byte_done = 1'b1;
`endif
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // Wait out a held-low line so it cannot look like a new start bit.
        cnt_d = '0;
        if (rxs_q == LINE_IDLE) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase

    rx_vld_d  = rx_vld_q;
    rx_dat_d  = rx_dat_q;
    overrun_d = 1'b0;
    if (byte_done) begin
      if (!rx_vld_q || rx_ready) begin
        rx_vld_d = 1'b1;
        rx_dat_d = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_vld_q && rx_ready) begin
      rx_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= RX_IDLE;
      rx_meta_q   <= LINE_IDLE;
      rxs_q       <= LINE_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_vld_q    <= 1'b0;
      rx_dat_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UARTPROBE_UART_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_vld_q    <= rx_vld_d;
      rx_dat_q    <= rx_dat_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UARTPROBE_UART_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign rx_valid     = rx_vld_q;
  assign rx_data      = rx_dat_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
`ifdef UARTPROBE_UART_PARITY_EN
  assign rx_parity_err = par_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: rtl/uartprobe_uart.sv
// Probe UART top: serial TX FSM here, receiver in uartprobe_uart_rx; tx_ready drops the cycle after accept and
// returns exactly one frame time later. Optional even parity via UARTPROBE_UART_PARITY_EN.
module uartprobe_uart
  import uartprobe_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BIT_CNT_W    = 16
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  localparam logic [BIT_CNT_W-1:0] FULL_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 line_q, line_d;
  logic                 tx_rdy_q, tx_rdy_d;
`ifdef UARTPROBE_UART_PARITY_EN
  logic                 par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + BIT_CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    line_d  = line_q;
`ifdef UARTPROBE_UART_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      TX_IDLE: begin
        cnt_d  = '0;
        line_d = LINE_IDLE;
        if (tx_valid && tx_rdy_q) begin
          shift_d = tx_data;
          idx_d   = '0;
          line_d  = ~LINE_IDLE;
          state_d = TX_START;
`ifdef UARTPROBE_UART_PARITY_EN
          par_d   = even_parity(tx_data);
`endif
        end
      end
      TX_START: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UARTPROBE_UART_PARITY_EN
            line_d  = par_q;
            state_d = TX_PARITY;
`else
            line_d  = LINE_IDLE;
            state_d = TX_STOP;
`endif
          end else begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UARTPROBE_UART_PARITY_EN
      TX_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          line_d  = LINE_IDLE;
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        line_d  = LINE_IDLE;
        state_d = TX_IDLE;
      end
    endcase

    tx_rdy_d = (state_d == TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      line_q   <= LINE_IDLE;
      tx_rdy_q <= 1'b1;
`ifdef UARTPROBE_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      tx_rdy_q <= tx_rdy_d;
`ifdef UARTPROBE_UART_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign uart_tx  = line_q;
  assign tx_ready = tx_rdy_q;

  uartprobe_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .BIT_CNT_W    (BIT_CNT_W)
  ) u_rx (
    .clk           (clk),
    .aresetn       (aresetn),
    .uart_rx       (uart_rx),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

endmodule

// File: tb/tb_uartprobe_uart.sv
// Directed bench for uartprobe_uart at CLKS_PER_BIT=16 (default 8N1 build).
module tb_uartprobe_uart;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       uart_rx;
  logic       uart_tx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_parity_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uartprobe_uart #(.CLKS_PER_BIT(CPB), .BIT_CNT_W(16)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

  typedef struct {
    logic [7:0] rx_byte;
    logic       rx_stop;
    logic [7:0] tx_byte;
    logic [9:0] tx_frame;  // line level per bit period, bit 0 = start bit
    int         exp_vld;
    logic [7:0] exp_dat;
    int         exp_fe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int hold);
    logic [7:0] bb;
    bb = b;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = bb[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    if (hold > 0) begin
      uart_rx = 1'b0;
      repeat (hold) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic rx_mon(input int cycles, output int nv, output logic [7:0] d,
                        output int nfe, output int nov, output int npe, output int ov_at);
    nv = 0; d = 8'h00; nfe = 0; nov = 0; npe = 0; ov_at = -1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin nv++; d = rx_data; end
      if (rx_frame_err !== 1'b0) nfe++;
      if (rx_overrun !== 1'b0) begin nov++; ov_at = i; end
      if (rx_parity_err !== 1'b0) npe++;
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic [9:0] exp);
    int bad, rbad;
    logic [9:0] ee;
    ee = exp;
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int k = 0; k < 10; k++) begin
      bad = 0; rbad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (uart_tx !== ee[k]) bad++;
        if (tx_ready !== 1'b0) rbad++;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d_%0h", k, b), bad, 0);
      check($sformatf("tx_busy%0d_%0h", k, b), rbad, 0);
    end
    check($sformatf("tx_ready_at_160_%0h", b), tx_ready, 1);
    check($sformatf("tx_idle_line_%0h", b), uart_tx, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    int nv, nfe, nov, npe, ov_at;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b1, 8'h3C, 10'b1001111000, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 8'hFF, 10'b1111111110, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'h00, 10'b1000000000, 1, 8'hFF, 0};
    vecs[3] = '{8'h81, 1'b1, 8'hA5, 10'b1101001010, 1, 8'h81, 0};
    vecs[4] = '{8'h55, 1'b0, 8'h5A, 10'b1010110100, 0, 8'h00, 1};

    aresetn  = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_parity_err", rx_parity_err, 0);
    aresetn = 1'b1;
    repeat (4) @(negedge clk);

    // Table: RX and TX frames run concurrently.
    for (int v = 0; v < 5; v++) begin
      fork
        send_rx(vecs[v].rx_byte, vecs[v].rx_stop, 0);
        tx_frame(vecs[v].tx_byte, vecs[v].tx_frame);
        rx_mon(200, nv, d, nfe, nov, npe, ov_at);
      join
      check($sformatf("v%0d_rx_valid_cycles", v), nv, vecs[v].exp_vld);
      if (vecs[v].exp_vld != 0) check($sformatf("v%0d_rx_data", v), d, vecs[v].exp_dat);
      check($sformatf("v%0d_frame_err", v), nfe, vecs[v].exp_fe);
      check($sformatf("v%0d_overrun", v), nov, 0);
      check($sformatf("v%0d_parity_err", v), npe, 0);
      repeat (5) @(negedge clk);
    end

    // Short low glitch must be rejected.
    fork
      begin
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
      end
      rx_mon(100, nv, d, nfe, nov, npe, ov_at);
    join
    check("glitch_rx_valid", nv, 0);
    check("glitch_frame_err", nfe, 0);
    check("glitch_overrun", nov, 0);

    // Framing error with a held-low break, then a clean frame.
    fork
      begin
        send_rx(8'h55, 1'b0, 100);
        repeat (20) @(negedge clk);
        send_rx(8'h12, 1'b1, 0);
      end
      rx_mon(500, nv, d, nfe, nov, npe, ov_at);
    join
    check("break_frame_err_pulses", nfe, 1);
    check("break_rx_valid_cycles", nv, 1);
    check("break_rx_data", d, 8'h12);
    check("break_overrun", nov, 0);

    // Overrun: hold 0x11 unconsumed, then 0x22 arrives.
    rx_ready = 1'b0;
    fork
      send_rx(8'h11, 1'b1, 0);
      rx_mon(200, nv, d, nfe, nov, npe, ov_at);
    join
    check("ovr_first_data", d, 8'h11);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_no_overrun", nov, 0);
    fork
      send_rx(8'h22, 1'b1, 0);
      rx_mon(200, nv, d, nfe, nov, npe, ov_at);
    join
    check("ovr_pulses", nov, 1);
    check("ovr_in_stop_bit", (ov_at >= 8 * CPB + 8 && ov_at < 10 * CPB), 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid_kept", rx_valid, 1);
    check("ovr_frame_err", nfe, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ovr_drain_valid", rx_valid, 0);
    repeat (5) @(negedge clk);

    // Reset during TX data bit 3 and mid RX frame.
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    uart_rx  = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB + 8 - CPB) @(negedge clk);
    check("prerst_tx_bit3", uart_tx, 0);
    check("prerst_tx_busy", tx_ready, 0);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    check("midrst_uart_tx", uart_tx, 1);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_valid", rx_valid, 0);
    rx_mon(200, nv, d, nfe, nov, npe, ov_at);
    check("postrst_no_byte", nv, 0);
    check("postrst_no_frame_err", nfe, 0);
    check("postrst_tx_idle", uart_tx, 1);
    fork
      send_rx(8'h7E, 1'b1, 0);
      rx_mon(200, nv, d, nfe, nov, npe, ov_at);
    join
    check("postrst_rx_valid_cycles", nv, 1);
    check("postrst_rx_data", d, 8'h7E);
    check("postrst_frame_err", nfe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uartprobe_uart.md
Name: uartprobe_uart

Overview:
UART modem that sits directly under the probe control FSM.
- Converts the serial `uart_rx` line into a valid/ready byte stream, and a valid/ready byte stream into serial `uart_tx`.
- Format: 8 data bits, LSB first, 1 stop bit, no parity.
- Provides a one-byte RX holding buffer and reports framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (434 = 50 MHz / 115200). Legal range is 4 or more.
- BIT_CNT_W, 16: width of the bit-period counter. Must satisfy 2^BIT_CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, single domain.
- aresetn  in  1  reset: synchronous, active-low.
- uart_rx  in  1  serial input, asynchronous to clk, idles high.
- uart_tx  out  1  serial output, idles high.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_data  out  8  received byte.
- rx_ready  in  1  consumer accepts rx_data in any cycle where rx_valid & rx_ready.
- tx_valid  in  1  byte offered for transmission.
- tx_data  in  8  byte to transmit.
- tx_ready  out  1  transmitter can accept a byte this cycle.
- rx_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- rx_overrun  out  1  one-cycle pulse when a received byte is dropped.
- rx_parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 without the optional feature.

Behaviour:
- Reset values (on clk edge while aresetn==0): uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error pulses=0, both FSMs IDLE, RX synchroniser flops=1.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser. All RX logic uses the synchronised value `rxs`.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK.
  - RX_IDLE: rxs==0 -> RX_START, counter cleared.
  - RX_START: at count CLKS_PER_BIT/2-1, sample rxs.
    - rxs==0 -> RX_DATA, counter cleared, bit index 0.
    - rxs==1 -> RX_IDLE (glitch rejected).
  - RX_DATA: at count CLKS_PER_BIT-1, sample rxs into the shift register (LSB first) and clear the counter. After index 7 -> RX_STOP.
  - RX_STOP: at count CLKS_PER_BIT-1, sample rxs.
    - rxs==1 -> byte complete, go RX_IDLE.
    - rxs==0 -> rx_frame_err pulse, byte discarded, go RX_BREAK.
  - RX_BREAK: stay until rxs==1, then RX_IDLE. This prevents retriggering during a held-low break.
- RX buffer, when a byte completes in cycle N:
  - rx_valid==0, or (rx_valid & rx_ready) in cycle N: load rx_data; rx_valid=1 from N+1.
  - rx_valid & !rx_ready in cycle N: new byte dropped, old rx_data kept, rx_overrun pulse in N+1.
  - Handshake with no new byte: rx_valid=0 from the next cycle.
  - rx_data is stable while rx_valid==1.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - tx_ready = (state==TX_IDLE), registered.
  - Accept on tx_valid & tx_ready: latch tx_data, go TX_START. uart_tx goes 0 at the next edge.
  - Each of the following lasts exactly CLKS_PER_BIT cycles: start bit (0), data bits LSB first, stop bit (1).
  - After the stop period -> TX_IDLE. tx_ready is high exactly 10*CLKS_PER_BIT cycles after the accept edge.
  - tx_data and tx_valid are ignored outside TX_IDLE.
- RX and TX are fully independent; simultaneous activity is legal.
- Reset mid-frame: both FSMs abort immediately. Any partial byte is lost; there is no glitch beyond uart_tx returning to 1.

Optional Feature:
- Macro: UARTPROBE_UART_PARITY_EN.
- Defined: an even-parity bit is inserted after data bit 7, on both TX and RX (state TX_PARITY / RX_PARITY, one bit period).
  - RX mismatch: byte discarded, rx_parity_err pulses for one cycle, FSM proceeds to RX_STOP normally.
  - Frame = 11*CLKS_PER_BIT.
- Undefined: 8N1 only, rx_parity_err tied 0, no parity state or logic.

Decomposition:
- Package uartprobe_uart_pkg: RX/TX state encodings, LINE_IDLE=1'b1, DATA_BITS=8, bit-index width (3).
- One natural sub-module: uartprobe_uart_rx (synchroniser, RX FSM, holding buffer, error pulses).
- TX stays in the top, which instantiates uartprobe_uart_rx.

Test Plan (CLKS_PER_BIT=16):
- Drive serial 0xA5 8N1 with rx_ready=1 -> rx_valid single-cycle high with rx_data=0xA5; no error pulses.
- tx_valid=1, tx_data=0x3C -> tx_ready=0 next cycle; uart_tx=0 for 16 cycles, then 0,0,1,1,1,1,0,0 at 16 cycles each, then 1 for 16 cycles; tx_ready=1 at cycle 160.
- uart_rx low pulse of 4 cycles -> returns to RX_IDLE; rx_valid and all error outputs stay 0.
- Frame 0x55 with stop bit 0, line held low 100 cycles, then frame 0x12 -> one rx_frame_err pulse, then rx_data=0x12 valid.
- rx_ready=0, send 0x11 then 0x22 -> rx_valid=1 with 0x11, rx_overrun pulse at the end of the 0x22 stop bit, rx_data still 0x11. Raise rx_ready -> rx_valid=0 next cycle.
- aresetn=0 for 1 cycle during TX data bit 3 and mid RX frame -> next edge uart_tx=1, tx_ready=1, rx_valid=0. A following 0x7E frame is received correctly.
